// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb -- single-port memory arbiter between the IFU fetch port and the LSU
// load/store port. Both requesters share one downstream memory bus and at most
// one transaction is outstanding at any time.
//
// Flow: IDLE (arbitrate, latch winner) -> REQ (drive bus until accepted)
//       -> WAIT (wait for response/ack) -> RESP (one-cycle valid pulse) -> IDLE.
//
// Build option:
//   MEM_ARB_RR_EN  defined   : round-robin arbitration between IFU and LSU.
//                  undefined : LSU has fixed priority, but IFU wins once the LSU
//                              has taken MAX_LSU_STREAK grants in a row while
//                              an IFU request was pending.
//
// Ports:
//   core_clk / core_rst      clock (rising edge) / async active-low reset
//   ifu_arb_*                IFU request (valid held until arb_ifu_ready)
//   arb_ifu_*                IFU ready pulse, fetched word, data-valid pulse
//   ifu_flush                discards the outstanding IFU response
//   lsu_arb_*                LSU request: addr, store data, dir, width
//   arb_lsu_*                LSU ready pulse, load data, done pulse
//   arb_mem_*                bus request: valid, addr, data, dir, width
//   mem_arb_*                bus accept, read data, response/ack
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int MAX_LSU_STREAK = 4,
  parameter int ADDR_W         = 64
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              ifu_arb_valid,
  input  logic [ADDR_W-1:0] ifu_arb_addr,
  output logic              arb_ifu_ready,
  output logic [31:0]       arb_ifu_data,
  output logic              arb_ifu_valid,
  input  logic              ifu_flush,
  input  logic              lsu_arb_valid,
  input  logic [ADDR_W-1:0] lsu_arb_addr,
  input  logic [63:0]       lsu_arb_data,
  input  logic              lsu_arb_dir,
  input  logic [3:0]        lsu_arb_width,
  output logic              arb_lsu_ready,
  output logic [63:0]       arb_lsu_data,
  output logic              arb_lsu_valid,
  output logic              arb_mem_valid,
  output logic [ADDR_W-1:0] arb_mem_addr,
  output logic [63:0]       arb_mem_data,
  output logic              arb_mem_dir,
  output logic [3:0]        arb_mem_width,
  input  logic              mem_arb_ready,
  input  logic [63:0]       mem_arb_data,
  input  logic              mem_arb_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  state_t state_reg;
  logic   owner_lsu_reg;    // owner of the in-flight transaction (1 = LSU)
  logic   ifu_drop_reg;     // in-flight IFU response must be swallowed
  logic   last_grant_reg;

  // A flushed IFU request is not eligible for a grant in that cycle.
  logic ifu_req;
  logic grant_lsu;
  logic grant_ifu;

  assign ifu_req = ifu_arb_valid & ~ifu_flush;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (ifu_req && lsu_arb_valid) begin
      // Contention: the side that did not win last time goes now.
      grant_lsu = (last_grant_reg == GRANT_IFU);
      grant_ifu = (last_grant_reg == GRANT_LSU);
    end else begin
      grant_lsu = lsu_arb_valid;
      grant_ifu = ifu_req;
    end
  end
`else
  localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

  logic [3:0] lsu_streak_reg;
  logic       streak_full;

  assign streak_full = (lsu_streak_reg == STREAK_MAX);

  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (lsu_arb_valid && !(ifu_req && streak_full)) begin
      grant_lsu = 1'b1;
    end else begin
      grant_ifu = ifu_req;
    end
  end

  // Counts back-to-back LSU grants taken while the IFU was waiting; saturates
  // at the limit so that a flush-blocked IFU cannot push it past the compare.
  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      lsu_streak_reg <= 4'd0;
    end else if (state_reg == IDLE) begin
      if (grant_lsu) begin
        if (!ifu_arb_valid) begin
          lsu_streak_reg <= 4'd0;
        end else if (!streak_full) begin
          lsu_streak_reg <= lsu_streak_reg + 4'd1;
        end
      end else if (grant_ifu) begin
        lsu_streak_reg <= 4'd0;
      end
    end
  end
`endif

  // Main FSM; all outputs are registered. Ready pulses become visible in the
  // first REQ cycle, together with arb_mem_valid.
  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      state_reg      <= IDLE;
      owner_lsu_reg  <= 1'b0;
      ifu_drop_reg   <= 1'b0;
      last_grant_reg <= GRANT_IFU;
      arb_ifu_ready  <= 1'b0;
      arb_ifu_data   <= 32'd0;
      arb_ifu_valid  <= 1'b0;
      arb_lsu_ready  <= 1'b0;
      arb_lsu_data   <= 64'd0;
      arb_lsu_valid  <= 1'b0;
      arb_mem_valid  <= 1'b0;
      arb_mem_addr   <= '0;
      arb_mem_data   <= 64'd0;
      arb_mem_dir    <= 1'b0;
      arb_mem_width  <= 4'd0;
    end else begin
      arb_ifu_ready <= 1'b0;
      arb_lsu_ready <= 1'b0;
      arb_ifu_valid <= 1'b0;
      arb_lsu_valid <= 1'b0;

      // A flush only marks the response for dropping; the bus side of the
      // transaction always runs to completion.
      if (ifu_flush && (state_reg != IDLE) && !owner_lsu_reg) begin
        ifu_drop_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (grant_lsu) begin
            arb_mem_addr   <= lsu_arb_addr;
            arb_mem_data   <= lsu_arb_data;
            arb_mem_dir    <= lsu_arb_dir;
            arb_mem_width  <= lsu_arb_width;
            arb_mem_valid  <= 1'b1;
            arb_lsu_ready  <= 1'b1;
            owner_lsu_reg  <= 1'b1;
            last_grant_reg <= GRANT_LSU;
            state_reg      <= REQ;
          end else if (grant_ifu) begin
            arb_mem_addr   <= ifu_arb_addr;
            arb_mem_data   <= 64'd0;
            arb_mem_dir    <= 1'b0;
            arb_mem_width  <= 4'd4;
            arb_mem_valid  <= 1'b1;
            arb_ifu_ready  <= 1'b1;
            owner_lsu_reg  <= 1'b0;
            last_grant_reg <= GRANT_IFU;
            state_reg      <= REQ;
          end
        end
        REQ: begin
          if (mem_arb_ready) begin
            arb_mem_valid <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_arb_valid) begin
            if (owner_lsu_reg) begin
              arb_lsu_data  <= mem_arb_data;
              arb_lsu_valid <= 1'b1;
            end else begin
              // 32-bit fetch out of a 64-bit beat: addr[2] picks the half.
              arb_ifu_data  <= arb_mem_addr[2] ? mem_arb_data[63:32] : mem_arb_data[31:0];
              // A flush arriving in this very cycle also kills the pulse.
              arb_ifu_valid <= ~(ifu_drop_reg | ifu_flush);
            end
            state_reg <= RESP;
          end
        end
        RESP: begin
          ifu_drop_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb -- directed self-checking bench for mem_arb. Inputs are driven and
// outputs sampled on the falling clock edge; every expected value is a
// hand-computed constant.
// -----------------------------------------------------------------------------
module tb_mem_arb;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        ifu_arb_valid;
  logic [63:0] ifu_arb_addr;
  logic        arb_ifu_ready;
  logic [31:0] arb_ifu_data;
  logic        arb_ifu_valid;
  logic        ifu_flush;
  logic        lsu_arb_valid;
  logic [63:0] lsu_arb_addr;
  logic [63:0] lsu_arb_data;
  logic        lsu_arb_dir;
  logic [3:0]  lsu_arb_width;
  logic        arb_lsu_ready;
  logic [63:0] arb_lsu_data;
  logic        arb_lsu_valid;
  logic        arb_mem_valid;
  logic [63:0] arb_mem_addr;
  logic [63:0] arb_mem_data;
  logic        arb_mem_dir;
  logic [3:0]  arb_mem_width;
  logic        mem_arb_ready;
  logic [63:0] mem_arb_data;
  logic        mem_arb_valid;

  int   checks = 0;
  int   errors = 0;
  logic who;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arb #(.MAX_LSU_STREAK(4), .ADDR_W(64)) dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .ifu_arb_valid (ifu_arb_valid),
    .ifu_arb_addr  (ifu_arb_addr),
    .arb_ifu_ready (arb_ifu_ready),
    .arb_ifu_data  (arb_ifu_data),
    .arb_ifu_valid (arb_ifu_valid),
    .ifu_flush     (ifu_flush),
    .lsu_arb_valid (lsu_arb_valid),
    .lsu_arb_addr  (lsu_arb_addr),
    .lsu_arb_data  (lsu_arb_data),
    .lsu_arb_dir   (lsu_arb_dir),
    .lsu_arb_width (lsu_arb_width),
    .arb_lsu_ready (arb_lsu_ready),
    .arb_lsu_data  (arb_lsu_data),
    .arb_lsu_valid (arb_lsu_valid),
    .arb_mem_valid (arb_mem_valid),
    .arb_mem_addr  (arb_mem_addr),
    .arb_mem_data  (arb_mem_data),
    .arb_mem_dir   (arb_mem_dir),
    .arb_mem_width (arb_mem_width),
    .mem_arb_ready (mem_arb_ready),
    .mem_arb_data  (mem_arb_data),
    .mem_arb_valid (mem_arb_valid)
  );

  always #5 core_clk = ~core_clk;

  task automatic step();
    @(negedge core_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step until exactly one ready pulse is seen (bounded); returns 1 for LSU.
  task automatic wait_grant(input string tag, output logic is_lsu);
    int n;
    n = 0;
    step();
    while (!arb_ifu_ready && !arb_lsu_ready && n < 12) begin
      step();
      n++;
    end
    checks++;
    assert ((arb_ifu_ready ^ arb_lsu_ready) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed ifu_ready=%0b lsu_ready=%0b expected one ready", tag,
             arb_ifu_ready, arb_lsu_ready);
    end
    is_lsu = arb_lsu_ready;
    $display("grant %s -> %s", tag, is_lsu ? "LSU" : "IFU");
  endtask

  // From a REQ-cycle negedge: accept now, respond next cycle; ends at RESP negedge.
  task automatic complete_txn(input logic [63:0] rdata);
    mem_arb_ready = 1'b1;
    step();
    mem_arb_ready = 1'b0;
    mem_arb_valid = 1'b1;
    mem_arb_data  = rdata;
    step();
    mem_arb_valid = 1'b0;
  endtask

  initial begin
    core_rst      = 1'b0;
    ifu_arb_valid = 1'b0;
    ifu_arb_addr  = 64'd0;
    ifu_flush     = 1'b0;
    lsu_arb_valid = 1'b0;
    lsu_arb_addr  = 64'd0;
    lsu_arb_data  = 64'd0;
    lsu_arb_dir   = 1'b0;
    lsu_arb_width = 4'd0;
    mem_arb_ready = 1'b0;
    mem_arb_data  = 64'd0;
    mem_arb_valid = 1'b0;

    // ---------------- reset state ----------------
    step();
    ifu_arb_valid = 1'b1;            // requests during reset must be ignored
    lsu_arb_valid = 1'b1;
    step();
    chk("rst_mem_valid", {63'd0, arb_mem_valid}, 64'd0);
    chk("rst_readies", {62'd0, arb_ifu_ready, arb_lsu_ready}, 64'd0);
    chk("rst_valids", {62'd0, arb_ifu_valid, arb_lsu_valid}, 64'd0);
    chk("rst_mem_addr", arb_mem_addr, 64'd0);
    chk("rst_mem_width", {59'd0, arb_mem_dir, arb_mem_width}, 64'd0);
    ifu_arb_valid = 1'b0;
    lsu_arb_valid = 1'b0;
    core_rst      = 1'b1;
    step();
    $display("reset released");

    // ---------------- IFU-only fetch ----------------
    ifu_arb_valid = 1'b1;
    ifu_arb_addr  = 64'h8000_0004;
    step();                                           // cycle 1 (REQ)
    chk("fetch_ready", {63'd0, arb_ifu_ready}, 64'd1);
    chk("fetch_mem_valid", {63'd0, arb_mem_valid}, 64'd1);
    chk("fetch_mem_addr", arb_mem_addr, 64'h8000_0004);
    chk("fetch_mem_width", {59'd0, arb_mem_dir, arb_mem_width}, 64'd4);
    ifu_arb_valid = 1'b0;
    mem_arb_ready = 1'b1;
    step();                                           // cycle 2 (WAIT)
    chk("fetch_mem_valid_drop", {63'd0, arb_mem_valid}, 64'd0);
    chk("fetch_no_early_valid", {63'd0, arb_ifu_valid}, 64'd0);
    mem_arb_ready = 1'b0;
    mem_arb_valid = 1'b1;
    mem_arb_data  = 64'h1111_2222_3333_4444;
    step();                                           // cycle 3 (RESP)
    mem_arb_valid = 1'b0;
    chk("fetch_valid", {63'd0, arb_ifu_valid}, 64'd1);
    chk("fetch_data", {32'd0, arb_ifu_data}, 64'h1111_2222);
    step();                                           // cycle 4 (IDLE)
    chk("fetch_valid_once", {63'd0, arb_ifu_valid}, 64'd0);
    $display("ifu fetch 0x80000004 data %h", arb_ifu_data);

    // ---------------- LSU store with stall ----------------
    lsu_arb_valid = 1'b1;
    lsu_arb_addr  = 64'h8000_1000;
    lsu_arb_data  = 64'hDEAD_BEEF_0000_0001;
    lsu_arb_dir   = 1'b1;
    lsu_arb_width = 4'd8;
    step();                                           // REQ
    chk("store_ready", {63'd0, arb_lsu_ready}, 64'd1);
    lsu_arb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("store_stall_valid", {63'd0, arb_mem_valid}, 64'd1);
      chk("store_stall_addr", arb_mem_addr, 64'h8000_1000);
      chk("store_stall_data", arb_mem_data, 64'hDEAD_BEEF_0000_0001);
      chk("store_stall_ctl", {59'd0, arb_mem_dir, arb_mem_width}, 64'h18);
      step();
    end
    chk("store_hold_after_stall", {63'd0, arb_mem_valid}, 64'd1);
    mem_arb_ready = 1'b1;
    step();                                           // WAIT
    mem_arb_ready = 1'b0;
    chk("store_accepted", {63'd0, arb_mem_valid}, 64'd0);
    step();                                           // WAIT, no ack yet
    chk("store_no_early_done", {63'd0, arb_lsu_valid}, 64'd0);
    mem_arb_valid = 1'b1;
    step();                                           // RESP
    mem_arb_valid = 1'b0;
    chk("store_done", {62'd0, arb_ifu_valid, arb_lsu_valid}, 64'd1);
    step();
    chk("store_done_once", {63'd0, arb_lsu_valid}, 64'd0);
    $display("lsu store 0x80001000 complete");

    // ---------------- simultaneous requests ----------------
    ifu_arb_valid = 1'b1;
    ifu_arb_addr  = 64'h0000_0100;
    lsu_arb_valid = 1'b1;
    lsu_arb_addr  = 64'h0000_0200;
    lsu_arb_dir   = 1'b0;
    lsu_arb_width = 4'd4;
    wait_grant("simul_first", who);
    chk("simul_first_who", {63'd0, who}, RR ? 64'd0 : 64'd1);
    if (who) begin
      lsu_arb_valid = 1'b0;
      chk("simul_lsu_addr", arb_mem_addr, 64'h200);
      complete_txn(64'hAAAA_BBBB_CCCC_DDDD);
      chk("simul_lsu_data", arb_lsu_data, 64'hAAAA_BBBB_CCCC_DDDD);
    end else begin
      ifu_arb_valid = 1'b0;
      complete_txn(64'h0123_4567_89AB_CDEF);
    end
    wait_grant("simul_second", who);
    chk("simul_second_who", {63'd0, who}, RR ? 64'd1 : 64'd0);
    if (!who) begin
      ifu_arb_valid = 1'b0;
      chk("simul_ifu_addr", arb_mem_addr, 64'h100);
      complete_txn(64'h0123_4567_89AB_CDEF);
      chk("simul_ifu_data", {32'd0, arb_ifu_data}, 64'h89AB_CDEF);
    end else begin
      lsu_arb_valid = 1'b0;
      complete_txn(64'hAAAA_BBBB_CCCC_DDDD);
    end

    // ---------------- starvation limit ----------------
    begin
      logic [4:0] exp_lsu;
      exp_lsu = RR ? 5'b01010 : 5'b01111;            // bit g = grant g
      ifu_arb_valid = 1'b1;
      ifu_arb_addr  = 64'h0000_0400;
      lsu_arb_valid = 1'b1;
      lsu_arb_addr  = 64'h0000_0300;
      lsu_arb_width = 4'd8;
      for (int g = 0; g < 5; g++) begin
        wait_grant("starve", who);
        chk("starve_order", {63'd0, who}, {63'd0, exp_lsu[g]});
        if (g == 4) begin
          ifu_arb_valid = 1'b0;
          lsu_arb_valid = 1'b0;
        end
        complete_txn(64'h0000_0000_5A5A_5A5A);
        chk("starve_resp_port", {62'd0, arb_lsu_valid, arb_ifu_valid},
            exp_lsu[g] ? 64'd2 : 64'd1);
      end
      step();
    end

    // ---------------- flush in IDLE blocks the grant ----------------
    ifu_arb_valid = 1'b1;
    ifu_arb_addr  = 64'h8000_0008;
    ifu_flush     = 1'b1;
    step();
    chk("flush_idle_no_grant", {62'd0, arb_ifu_ready, arb_mem_valid}, 64'd0);
    ifu_flush = 1'b0;

    // ---------------- flush during fetch ----------------
    wait_grant("flush_fetch", who);
    chk("flush_fetch_who", {63'd0, who}, 64'd0);
    ifu_arb_valid = 1'b0;
    mem_arb_ready = 1'b1;
    step();                                           // WAIT
    mem_arb_ready = 1'b0;
    ifu_flush     = 1'b1;
    step();                                           // still WAIT
    ifu_flush     = 1'b0;
    mem_arb_valid = 1'b1;
    mem_arb_data  = 64'hFFFF_EEEE_DDDD_CCCC;
    step();                                           // RESP
    mem_arb_valid = 1'b0;
    chk("flush_suppressed", {63'd0, arb_ifu_valid}, 64'd0);
    step();
    chk("flush_still_quiet", {63'd0, arb_ifu_valid}, 64'd0);
    ifu_arb_valid = 1'b1;
    ifu_arb_addr  = 64'h8000_000C;
    wait_grant("after_flush", who);
    chk("after_flush_who", {63'd0, who}, 64'd0);
    ifu_arb_valid = 1'b0;
    complete_txn(64'h5555_6666_7777_8888);
    chk("after_flush_valid", {63'd0, arb_ifu_valid}, 64'd1);
    chk("after_flush_data", {32'd0, arb_ifu_data}, 64'h5555_6666);
    step();

    // ---------------- reset mid-transaction ----------------
    lsu_arb_valid = 1'b1;
    lsu_arb_addr  = 64'h0000_0800;
    lsu_arb_dir   = 1'b0;
    wait_grant("pre_reset", who);
    lsu_arb_valid = 1'b0;
    chk("pre_reset_mem_valid", {63'd0, arb_mem_valid}, 64'd1);
    #2 core_rst = 1'b0;
    #1;
    chk("async_reset_mem_valid", {62'd0, arb_mem_valid, arb_lsu_ready}, 64'd0);
    step();
    core_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_arb_ready = 1'b1;
      mem_arb_valid = 1'b1;
      step();
      chk("post_reset_quiet", {61'd0, arb_mem_valid, arb_lsu_valid, arb_ifu_valid}, 64'd0);
    end
    mem_arb_ready = 1'b0;
    mem_arb_valid = 1'b0;
    ifu_arb_valid = 1'b1;
    ifu_arb_addr  = 64'h8000_0000;
    wait_grant("post_reset_fetch", who);
    chk("post_reset_who", {63'd0, who}, 64'd0);
    ifu_arb_valid = 1'b0;
    complete_txn(64'h9999_AAAA_BBBB_CCCC);
    chk("post_reset_data", {31'd0, arb_ifu_valid, arb_ifu_data}, 64'h1_BBBB_CCCC);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Single-port memory arbiter between the IFU fetch port and the LSU load/store port. Both share one downstream memory bus.
- Sits between the core's ifu/lsu memory interfaces and the memory model/bus, replacing the two separate memory ports with one.
- Each requester issues one transaction at a time. The arbiter latches the winner, drives the bus, waits for the response and routes it back.
- At most one transaction is outstanding at any time.

Parameters:
- MAX_LSU_STREAK, 4: maximum consecutive LSU grants while an IFU request is pending. Range 1-15.
- ADDR_W, 64: address width.

Ports:
- core_clk  in  1  core clock; all state on rising edge.
- core_rst  in  1  asynchronous, active-low reset.
- ifu_arb_valid  in  1  IFU fetch request; held until arb_ifu_ready.
- ifu_arb_addr  in  ADDR_W  fetch address.
- arb_ifu_ready  out  1  1-cycle pulse: IFU request latched.
- arb_ifu_data  out  32  fetched instruction.
- arb_ifu_valid  out  1  1-cycle pulse: arb_ifu_data valid.
- ifu_flush  in  1  pc_clear_all; discards any outstanding IFU response.
- lsu_arb_valid  in  1  LSU request; held until arb_lsu_ready.
- lsu_arb_addr  in  ADDR_W  load/store address.
- lsu_arb_data  in  64  store data.
- lsu_arb_dir  in  1  0 = read, 1 = write.
- lsu_arb_width  in  4  access width in bytes (1, 2, 4, 8).
- arb_lsu_ready  out  1  1-cycle pulse: LSU request latched.
- arb_lsu_data  out  64  load data; store ack carries don't-care data.
- arb_lsu_valid  out  1  1-cycle pulse: load data valid / store complete.
- arb_mem_valid  out  1  bus request.
- arb_mem_addr  out  ADDR_W  bus address.
- arb_mem_data  out  64  bus write data.
- arb_mem_dir  out  1  0 = read, 1 = write.
- arb_mem_width  out  4  bus width in bytes; IFU always 4.
- mem_arb_ready  in  1  bus accepts the request this cycle.
- mem_arb_data  in  64  bus read data.
- mem_arb_valid  in  1  bus response or write ack.

Behaviour:
- Reset (core_rst = 0, async):
  - State = IDLE; every output = 0; lsu_streak = 0; ifu_drop = 0; last_grant = IFU.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Arbitrate among valid requesters.
  - Fixed priority is LSU over IFU, except when ifu_arb_valid is set and lsu_streak == MAX_LSU_STREAK; then IFU wins.
  - Winner's fields are registered into the arb_mem_* outputs and its arb_*_ready pulses in this cycle.
  - Next state REQ, with arb_mem_valid = 1 from the next cycle.
  - No valid requester: stay in IDLE.
- lsu_streak:
  - LSU grant while ifu_arb_valid = 1: increment, saturating.
  - Any IFU grant: clear.
  - LSU grant while ifu_arb_valid = 0: clear.
- REQ:
  - arb_mem_valid = 1; addr/data/dir/width stay stable.
  - mem_arb_ready = 1 → arb_mem_valid cleared, go to WAIT.
  - Otherwise hold in REQ indefinitely.
- WAIT:
  - mem_arb_valid = 1 → capture the response, go to RESP.
  - IFU data is mem_arb_data[31:0] if latched addr[2] = 0, else mem_arb_data[63:32].
  - LSU data is mem_arb_data[63:0] unmodified; sign/zero extension is the LSU's job.
- RESP:
  - Pulse arb_ifu_valid or arb_lsu_valid for exactly one cycle.
  - For an IFU transaction, suppress the pulse if ifu_drop = 1.
  - Next state IDLE; clear ifu_drop.
- ifu_flush:
  - Asserted while an IFU transaction is in REQ/WAIT/RESP → set ifu_drop. The bus transaction still completes normally; it is never aborted.
  - Asserted in IDLE → the IFU request is not granted that cycle.
  - Has no effect on LSU transactions.
- mem_arb_valid in IDLE or REQ: ignored, with no state change.
- Minimum latency:
  - Request at cycle 0, ready at cycle 1, response at cycle 2 → arb_*_valid at cycle 3.
  - Next grant possible at cycle 4.
- Both requesters valid and simultaneous in IDLE: exactly one is granted. The loser keeps valid asserted and is arbitrated again in the next IDLE cycle.
- The arbiter never generates a transaction without an accepted request.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - IDLE arbitration is round-robin. When both requesters are valid, grant the one not equal to last_grant.
  - last_grant updates on every grant; lsu_streak and MAX_LSU_STREAK are unused.
- MEM_ARB_RR_EN undefined: fixed LSU priority with the streak limit described above.

Test Plan:
- IFU-only fetch:
  - Stimulus: addr 0x8000_0004; mem returns 0x1111_2222_3333_4444 with ready at cycle 1 and response at cycle 2.
  - Required: arb_mem_width = 4; arb_ifu_data = 0x1111_2222; arb_ifu_valid pulses once at cycle 3.
- LSU store with stall:
  - Stimulus: dir = 1, width = 8, addr 0x8000_1000, data 0xDEAD_BEEF_0000_0001; mem_arb_ready low for 3 cycles.
  - Required: arb_mem_* held stable through the stall; arb_lsu_valid pulses once, one cycle after mem_arb_valid.
- Simultaneous requests, default build:
  - Stimulus: IFU and LSU both valid in the same IDLE cycle.
  - Required: LSU granted first, IFU second.
- Starvation limit, default build:
  - Stimulus: LSU valid continuously with MAX_LSU_STREAK = 4, IFU valid.
  - Required: grant order LSU, LSU, LSU, LSU, IFU.
  - With MEM_ARB_RR_EN defined, the same stimulus gives LSU, IFU, LSU, IFU.
- Flush during fetch:
  - Stimulus: ifu_flush pulsed while in WAIT.
  - Required: bus response consumed; arb_ifu_valid stays 0; next IFU request served normally.
- Reset mid-transaction:
  - Stimulus: core_rst driven low while in REQ.
  - Required: arb_mem_valid = 0 immediately (asynchronous); FSM returns to IDLE; no response pulse afterwards.
